// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control FSM: FETCH/DECODE/EXEC/MEM/WB plus a halting TRAP state.
// Control strobes decode from state and instruction fields; trap, cause and retire count are registered.
module multicycle_control_unit #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               mem_ready,
  input  logic               trap_clr,
  output logic [1:0]         selSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Branch,
  output logic               Jump,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [CNT_W-1:0]   retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4,
                         A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_SLT = 4'd8, A_SLTU = 4'd9;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic              r_trap;
  logic [1:0]        r_cause;
  logic [CNT_W-1:0]  r_retire;

  logic              w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_is_jmp, w_legal;
  logic [3:0]        w_alu_r, w_alu_i, w_alu;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_timeout;

  assign w_is_r   = (opcode == OP_R);
  assign w_is_i   = (opcode == OP_I);
  assign w_is_ld  = (opcode == OP_LD);
  assign w_is_st  = (opcode == OP_ST);
  assign w_is_br  = (opcode == OP_BR);
  assign w_is_jmp = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign w_legal  = w_is_r || w_is_i || w_is_ld || w_is_st || w_is_br || w_is_jmp;

  // Memory handshake: mem_ready=1 in a cycle where MemRead/MemWrite is driven completes that
  // access at the next rising edge; each cycle without it counts toward MEM_TIMEOUT.
  assign w_wait_inc = r_wait + WAIT_W'(1);
  assign w_timeout  = (MEM_TIMEOUT != 0) && (w_wait_inc == WAIT_W'(MEM_TIMEOUT));

  always_comb begin
    w_alu_r = A_ADD;
    case ({funct7, funct3})
      10'b0000000_000: w_alu_r = A_ADD;
      10'b0100000_000: w_alu_r = A_SUB;
      10'b0000000_001: w_alu_r = A_SLL;
      10'b0000000_010: w_alu_r = A_SLT;
      10'b0000000_011: w_alu_r = A_SLTU;
      10'b0000000_100: w_alu_r = A_XOR;
      10'b0000000_101: w_alu_r = A_SRL;
      10'b0100000_101: w_alu_r = A_SRA;
      10'b0000000_110: w_alu_r = A_OR;
      10'b0000000_111: w_alu_r = A_AND;
      default:         w_alu_r = A_ADD;
    endcase
  end

  always_comb begin
    w_alu_i = A_ADD;
    case (funct3)
      3'b000:  w_alu_i = A_ADD;
      3'b001:  w_alu_i = A_SLL;
      3'b010:  w_alu_i = A_SLT;
      3'b011:  w_alu_i = A_SLTU;
      3'b100:  w_alu_i = A_XOR;
      3'b101:  w_alu_i = (funct7 == 7'b0000000) ? A_SRL : A_SRA;
      3'b110:  w_alu_i = A_OR;
      default: w_alu_i = A_AND;
    endcase
  end

  always_comb begin
    selSrc   = 2'b00;
    w_alu    = A_ADD;
    Branch   = 1'b0;
    Jump     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        // Held low during reset so a stale mem_ready cannot latch an instruction.
        IRWrite = mem_ready && rst_n;
        PCWrite = mem_ready && rst_n;
      end
      S_EXEC: begin
        if (w_is_r) begin
          w_alu = w_alu_r;
        end else if (w_is_i) begin
          selSrc = 2'b01;
          w_alu  = w_alu_i;
        end else if (w_is_ld || w_is_st) begin
          selSrc = 2'b01;
        end else if (w_is_br) begin
          w_alu  = A_SUB;
          Branch = 1'b1;
        end else if (w_is_jmp) begin
          selSrc = 2'b01;
          Jump   = 1'b1;
        end
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = w_is_ld;
        MemWrite = w_is_st;
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemToReg = w_is_ld;
      end
      default: ;
    endcase
    ALUOp = ALUOP_W'(w_alu);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_wait   <= '0;
      r_trap   <= 1'b0;
      r_cause  <= 2'b00;
      r_retire <= '0;
    end else begin
      case (r_state)
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            r_wait <= '0;
            if (r_state == S_FETCH) begin
              r_state <= S_DECODE;
            end else if (w_is_st) begin
              r_state  <= S_FETCH;
              r_retire <= r_retire + CNT_W'(1);
            end else begin
              r_state <= S_WB;
            end
          end else if (w_timeout) begin
            r_wait  <= '0;
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= 2'b10;
          end else begin
            r_wait <= w_wait_inc;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= 2'b01;
          end
        end
        S_EXEC: begin
          if (w_is_ld || w_is_st) begin
            r_state <= S_MEM;
          end else if (w_is_br) begin
            r_state  <= S_FETCH;
            r_retire <= r_retire + CNT_W'(1);
          end else if (w_is_r || w_is_i || w_is_jmp) begin
            r_state <= S_WB;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_WB: begin
          r_state  <= S_FETCH;
          r_retire <= r_retire + CNT_W'(1);
        end
        S_TRAP: begin
          if (trap_clr) begin
            r_state <= S_FETCH;
            r_trap  <= 1'b0;
            r_cause <= 2'b00;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign trap       = r_trap;
  assign trap_cause = r_cause;
  assign retire_cnt = r_retire;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: each cycle's expected output vector is queued
// by the driver and compared by a negedge monitor.
module tb_multicycle_control_unit;

  logic       clk, rst_n;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       mem_ready, trap_clr;
  logic [1:0] selSrc, trap_cause;
  logic [3:0] ALUOp, retire_cnt;
  logic       Branch, Jump, MemRead, MemWrite, IorD, IRWrite, PCWrite, MemToReg, RegWrite, trap;

  multicycle_control_unit #(.ALUOP_W(4), .MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .trap_clr(trap_clr), .selSrc(selSrc), .ALUOp(ALUOp),
    .Branch(Branch), .Jump(Jump), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .trap(trap), .trap_cause(trap_cause), .retire_cnt(retire_cnt)
  );

  // Flag order: Branch Jump MemRead MemWrite IorD IRWrite PCWrite MemToReg RegWrite trap
  localparam logic [9:0] F_NONE = 10'b0000000000, F_FETCH = 10'b0010000000,
                         F_FRDY = 10'b0010011000, F_BR = 10'b1000000000,
                         F_JMP  = 10'b0100000000, F_LDM = 10'b0010100000,
                         F_STM  = 10'b0001100000, F_WB = 10'b0000000010,
                         F_WBLD = 10'b0000000110, F_TRAP = 10'b0000000001;

  logic [21:0] exp_q[$];
  string       name_q[$];
  int          total, bad;
  logic [3:0]  rc;
  logic [21:0] act;

  assign act = {selSrc, ALUOp, Branch, Jump, MemRead, MemWrite, IorD, IRWrite, PCWrite,
                MemToReg, RegWrite, trap, trap_cause, retire_cnt};

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] vec(input logic [1:0] sel, input logic [3:0] aop,
                                      input logic [9:0] fl, input logic [1:0] cause,
                                      input logic [3:0] cnt);
    return {sel, aop, fl, cause, cnt};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [21:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h (t=%0t)", nm, act, e, $time);
      end
    end
  end

  // Driver tasks
  task automatic expect_vec(input logic [21:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input logic rdy, input logic clr, input logic [21:0] e, input string nm);
    @(posedge clk); #1;
    mem_ready = rdy;
    trap_clr  = clr;
    expect_vec(e, nm);
  endtask

  task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input int nwait, input string nm);
    for (int i = 0; i <= nwait; i++) begin
      @(posedge clk); #1;
      rst_n = 1'b1; opcode = op; funct3 = f3; funct7 = f7; trap_clr = 1'b0;
      mem_ready = (i == nwait);
      expect_vec(vec(2'b00, 4'd0, (i == nwait) ? F_FRDY : F_FETCH, 2'b00, rc), nm);
    end
  endtask

  task automatic alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [1:0] sel, input logic [3:0] aop, input int nwait,
                     input string nm);
    fetch(op, f3, f7, nwait, nm);
    step(1'b1, 1'b0, vec(2'b00, 4'd0, F_NONE, 2'b00, rc), nm);
    step(1'b0, 1'b0, vec(sel, aop, F_NONE, 2'b00, rc), nm);
    step(1'b0, 1'b0, vec(2'b00, 4'd0, F_WB, 2'b00, rc), nm);
    rc = rc + 4'd1;
  endtask

  task automatic jump(input logic [6:0] op, input string nm);
    fetch(op, 3'b000, 7'd0, 0, nm);
    step(1'b0, 1'b0, vec(2'b00, 4'd0, F_NONE, 2'b00, rc), nm);
    step(1'b0, 1'b0, vec(2'b01, 4'd0, F_JMP, 2'b00, rc), nm);
    step(1'b0, 1'b0, vec(2'b00, 4'd0, F_WB, 2'b00, rc), nm);
    rc = rc + 4'd1;
  endtask

  task automatic load(input int nwait, input string nm);
    fetch(7'b0000011, 3'b010, 7'd0, 0, nm);
    step(1'b0, 1'b0, vec(2'b00, 4'd0, F_NONE, 2'b00, rc), nm);
    step(1'b0, 1'b0, vec(2'b01, 4'd0, F_NONE, 2'b00, rc), nm);
    for (int i = 0; i < nwait; i++) step(1'b0, 1'b0, vec(2'b00, 4'd0, F_LDM, 2'b00, rc), nm);
    step(1'b1, 1'b0, vec(2'b00, 4'd0, F_LDM, 2'b00, rc), nm);
    step(1'b0, 1'b0, vec(2'b00, 4'd0, F_WBLD, 2'b00, rc), nm);
    rc = rc + 4'd1;
  endtask

  task automatic store(input string nm);
    fetch(7'b0100011, 3'b010, 7'd0, 0, nm);
    step(1'b0, 1'b0, vec(2'b00, 4'd0, F_NONE, 2'b00, rc), nm);
    step(1'b0, 1'b0, vec(2'b01, 4'd0, F_NONE, 2'b00, rc), nm);
    step(1'b1, 1'b0, vec(2'b00, 4'd0, F_STM, 2'b00, rc), nm);
    rc = rc + 4'd1;
  endtask

  task automatic branch(input string nm);
    fetch(7'b1100011, 3'b000, 7'd0, 0, nm);
    step(1'b0, 1'b0, vec(2'b00, 4'd0, F_NONE, 2'b00, rc), nm);
    step(1'b0, 1'b0, vec(2'b00, 4'd1, F_BR, 2'b00, rc), nm);
    rc = rc + 4'd1;
  endtask

  task automatic trap_hold(input logic [1:0] cause, input string nm);
    step(1'b1, 1'b0, vec(2'b00, 4'd0, F_TRAP, cause, rc), nm);
    step(1'b0, 1'b0, vec(2'b00, 4'd0, F_TRAP, cause, rc), nm);
    step(1'b0, 1'b1, vec(2'b00, 4'd0, F_TRAP, cause, rc), nm);
  endtask

  task automatic async_rst(input string nm);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    trap_clr  = 1'b0;
    #2 rst_n = 1'b0;
    expect_vec(vec(2'b00, 4'd0, F_FETCH, 2'b00, 4'd0), nm);
    rc = 4'd0;
  endtask

  initial begin
    total = 0; bad = 0; rc = 4'd0;
    rst_n = 1'b0; mem_ready = 1'b1; trap_clr = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;

    step(1'b1, 1'b0, vec(2'b00, 4'd0, F_FETCH, 2'b00, 4'd0), "reset_hold");

    alu(7'b0110011, 3'b000, 7'b0000000, 2'b00, 4'd0, 0, "add");
    alu(7'b0110011, 3'b000, 7'b0100000, 2'b00, 4'd1, 0, "sub");
    alu(7'b0110011, 3'b111, 7'b0000000, 2'b00, 4'd2, 0, "and");
    alu(7'b0110011, 3'b110, 7'b0000000, 2'b00, 4'd3, 0, "or");
    alu(7'b0110011, 3'b100, 7'b0000000, 2'b00, 4'd4, 0, "xor");
    alu(7'b0110011, 3'b001, 7'b0000000, 2'b00, 4'd5, 0, "sll");
    alu(7'b0110011, 3'b101, 7'b0000000, 2'b00, 4'd6, 0, "srl");
    alu(7'b0110011, 3'b101, 7'b0100000, 2'b00, 4'd7, 0, "sra");
    alu(7'b0110011, 3'b010, 7'b0000000, 2'b00, 4'd8, 0, "slt");
    alu(7'b0110011, 3'b011, 7'b0000000, 2'b00, 4'd9, 0, "sltu");
    alu(7'b0110011, 3'b000, 7'b0000001, 2'b00, 4'd0, 0, "r_unlisted");
    alu(7'b0010011, 3'b000, 7'b0100000, 2'b01, 4'd0, 0, "addi");
    alu(7'b0010011, 3'b101, 7'b0100000, 2'b01, 4'd7, 0, "srai");
    alu(7'b0010011, 3'b101, 7'b0000000, 2'b01, 4'd6, 0, "srli");
    alu(7'b0010011, 3'b001, 7'b0000000, 2'b01, 4'd5, 0, "slli");
    alu(7'b0010011, 3'b011, 7'b0000000, 2'b01, 4'd9, 0, "sltiu");
    alu(7'b0010011, 3'b111, 7'b0000000, 2'b01, 4'd2, 0, "andi");

    load(3, "lw_wait3");
    load(0, "lw");
    store("sw");
    branch("beq");
    jump(7'b1101111, "jal");
    jump(7'b1100111, "jalr");

    // Illegal opcode traps; trap_clr during DECODE has no effect.
    fetch(7'b1111111, 3'b000, 7'd0, 0, "illegal");
    step(1'b0, 1'b1, vec(2'b00, 4'd0, F_NONE, 2'b00, rc), "illegal_dec");
    trap_hold(2'b01, "illegal_trap");
    alu(7'b0110011, 3'b000, 7'b0000000, 2'b00, 4'd0, 0, "add_after_trap");

    // Fetch: mem_ready in the 4th wait cycle completes; 4 misses time out.
    alu(7'b0110011, 3'b100, 7'b0000000, 2'b00, 4'd4, 3, "fetch_wait3");
    repeat (4) step(1'b0, 1'b0, vec(2'b00, 4'd0, F_FETCH, 2'b00, rc), "fetch_to");
    trap_hold(2'b10, "fetch_to_trap");

    // Store timing out in MEM drops MemWrite and does not retire.
    fetch(7'b0100011, 3'b010, 7'd0, 0, "sw_to");
    step(1'b0, 1'b0, vec(2'b00, 4'd0, F_NONE, 2'b00, rc), "sw_to");
    step(1'b0, 1'b0, vec(2'b01, 4'd0, F_NONE, 2'b00, rc), "sw_to");
    repeat (4) step(1'b0, 1'b0, vec(2'b00, 4'd0, F_STM, 2'b00, rc), "sw_to_mem");
    trap_hold(2'b10, "sw_to_trap");
    store("sw_after_to");

    // Asynchronous reset mid-MEM of a load.
    fetch(7'b0000011, 3'b010, 7'd0, 0, "lw_rst");
    step(1'b0, 1'b0, vec(2'b00, 4'd0, F_NONE, 2'b00, rc), "lw_rst");
    step(1'b0, 1'b0, vec(2'b01, 4'd0, F_NONE, 2'b00, rc), "lw_rst");
    step(1'b0, 1'b0, vec(2'b00, 4'd0, F_LDM, 2'b00, rc), "lw_rst_mem");
    async_rst("async_reset");
    step(1'b1, 1'b0, vec(2'b00, 4'd0, F_FETCH, 2'b00, 4'd0), "reset_hold2");

    // 16 retirements wrap the 4-bit counter back to 0.
    repeat (16) branch("wrap_beq");
    alu(7'b0110011, 3'b000, 7'b0000000, 2'b00, 4'd0, 0, "add_wrapped");

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
